// File: rtl/scoreboard_regfile_if.sv
// Operand read, issue, writeback and flush signals between pipeline and scoreboard register file.
interface scoreboard_regfile_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic            rs1Busy;
  logic            rs2Busy;
  logic            issueValid;
  logic [AW-1:0]   issueRd;
  logic            issueReady;
  logic            wbEnable0;
  logic            wbEnable1;
  logic [AW-1:0]   wbRd0;
  logic [AW-1:0]   wbRd1;
  logic [XLEN-1:0] wbData0;
  logic [XLEN-1:0] wbData1;
  logic            flush;
  logic [CW-1:0]   busyCount;

  modport master (
    output rs1, rs2, issueValid, issueRd, wbEnable0, wbEnable1, wbRd0, wbRd1,
           wbData0, wbData1, flush,
    input  readData1, readData2, rs1Busy, rs2Busy, issueReady, busyCount
  );

  modport slave (
    input  rs1, rs2, issueValid, issueRd, wbEnable0, wbEnable1, wbRd0, wbRd1,
           wbData0, wbData1, flush,
    output readData1, readData2, rs1Busy, rs2Busy, issueReady, busyCount
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy bits, two writeback ports with bypass, and
// issue gating against pending producers.
module scoreboard_regfile #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  scoreboard_regfile_if.slave bus
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   count_q;

  logic wb0_valid, wb1_valid;
  logic wb_hit_rs1, wb_hit_rs2, wb_hit_issue;
  logic issue_ready, issue_fire;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  assign wb0_valid = bus.wbEnable0 && (bus.wbRd0 != '0);
  assign wb1_valid = bus.wbEnable1 && (bus.wbRd1 != '0);

  assign wb_hit_rs1 = (wb0_valid && bus.wbRd0 == bus.rs1) ||
                      (wb1_valid && bus.wbRd1 == bus.rs1);
  assign wb_hit_rs2 = (wb0_valid && bus.wbRd0 == bus.rs2) ||
                      (wb1_valid && bus.wbRd1 == bus.rs2);
  assign wb_hit_issue = (wb0_valid && bus.wbRd0 == bus.issueRd) ||
                        (wb1_valid && bus.wbRd1 == bus.issueRd);

  // Bypass: port 1 (load) beats port 0 (ALU), both beat the stored value.
  always_comb begin
    bus.readData1 = '0;
    if (bus.rs1 != '0) begin
      if (wb1_valid && bus.wbRd1 == bus.rs1)      bus.readData1 = bus.wbData1;
      else if (wb0_valid && bus.wbRd0 == bus.rs1) bus.readData1 = bus.wbData0;
      else                                        bus.readData1 = regs_q[bus.rs1];
    end
  end

  always_comb begin
    bus.readData2 = '0;
    if (bus.rs2 != '0) begin
      if (wb1_valid && bus.wbRd1 == bus.rs2)      bus.readData2 = bus.wbData1;
      else if (wb0_valid && bus.wbRd0 == bus.rs2) bus.readData2 = bus.wbData0;
      else                                        bus.readData2 = regs_q[bus.rs2];
    end
  end

  assign bus.rs1Busy = (bus.rs1 != '0) && busy_q[bus.rs1] && !wb_hit_rs1;
  assign bus.rs2Busy = (bus.rs2 != '0) && busy_q[bus.rs2] && !wb_hit_rs2;

  assign issue_ready = !bus.flush &&
                       ((bus.issueRd == '0) || !busy_q[bus.issueRd] || wb_hit_issue);
  assign issue_fire  = bus.issueValid && issue_ready && (bus.issueRd != '0);
  assign bus.issueReady = issue_ready;
  assign bus.busyCount  = count_q;

  // Issue set is applied after writeback clears so it wins on the same index.
  always_comb begin
    busy_d = busy_q;
    if (wb0_valid) busy_d[bus.wbRd0] = 1'b0;
    if (wb1_valid) busy_d[bus.wbRd1] = 1'b0;
    if (issue_fire) busy_d[bus.issueRd] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= popcount(busy_d);
    end
  end

  // Port 1 is written last so it takes priority on a shared destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wb0_valid) regs_q[bus.wbRd0] <= bus.wbData0;
      if (wb1_valid) regs_q[bus.wbRd1] <= bus.wbData1;
    end
  end
endmodule
